// File: rtl/spshift_pkg.sv
// Shared types and helpers for the spshift_ctrl sequencing controller.
package spshift_pkg;

  typedef enum logic [1:0] {INIT, FILL, PAD, FULL} spshift_state_t;

  function automatic int spshift_lw(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/modcounter.sv
// Saturating up counter holding the number of chunks currently in the shift register.
module modcounter #(
  parameter int W   = 2,
  parameter int MOD = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A clear with a simultaneous increment restarts the count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q < W'(MOD))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/spshift_ctrl.sv
// Chunk-to-word sequencing controller driving an external spshiftreg.
// Define SPSHIFT_CTRL_FLUSH_EN to enable zero-padded partial-word flushing.
module spshift_ctrl
  import spshift_pkg::*;
#(
  parameter int N  = 4,
  parameter int M  = 2,
  parameter int LW = spshift_lw(M)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N-1:0]  s_data,
`ifdef SPSHIFT_CTRL_FLUSH_EN
  input  logic          flush,
  output logic          m_partial,
`endif
  output logic          m_valid,
  input  logic          m_ready,
  output logic          sr_en,
  output logic          sr_clr,
  output logic [N-1:0]  sr_sin,
  output logic [LW-1:0] level
);

  spshift_state_t state_q;
  spshift_state_t state_d;
  logic           m_valid_q;
  logic           lvl_inc;
  logic           lvl_clr;
  logic           last_slot;

`ifdef SPSHIFT_CTRL_FLUSH_EN
  logic           m_partial_q;
  logic           m_partial_d;
`endif

  modcounter #(
    .W   (LW),
    .MOD (M)
  ) u_level (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (lvl_inc),
    .clr     (lvl_clr),
    .count   (level)
  );

  // The next shift completes the word.
  assign last_slot = (level == LW'(M - 1));

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    sr_en   = 1'b0;
    sr_clr  = 1'b0;
    sr_sin  = '0;
    lvl_inc = 1'b0;
    lvl_clr = 1'b0;
`ifdef SPSHIFT_CTRL_FLUSH_EN
    m_partial_d = m_partial_q;
`endif
    case (state_q)
      INIT: begin
        sr_clr  = 1'b1;
        state_d = FILL;
      end
      FILL: begin
`ifdef SPSHIFT_CTRL_FLUSH_EN
        if (flush && (level != '0)) begin
          sr_en       = 1'b1;
          lvl_inc     = 1'b1;
          state_d     = last_slot ? FULL : PAD;
          m_partial_d = last_slot;
        end else
`endif
        begin
          s_ready = 1'b1;
          sr_sin  = s_data;
          sr_en   = s_valid;
          lvl_inc = s_valid;
          if (s_valid && last_slot) begin
            state_d = FULL;
          end
        end
      end
`ifdef SPSHIFT_CTRL_FLUSH_EN
      PAD: begin
        sr_en   = 1'b1;
        lvl_inc = 1'b1;
        if (last_slot) begin
          state_d     = FULL;
          m_partial_d = 1'b1;
        end
      end
`endif
      FULL: begin
        s_ready = m_ready;
        if (m_ready) begin
          sr_sin  = s_data;
          sr_en   = s_valid;
          lvl_clr = 1'b1;
          lvl_inc = s_valid;
          state_d = FILL;
`ifdef SPSHIFT_CTRL_FLUSH_EN
          m_partial_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= (state_d == FULL);
    end
  end

`ifdef SPSHIFT_CTRL_FLUSH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_partial_q <= 1'b0;
    end else begin
      m_partial_q <= m_partial_d;
    end
  end

  assign m_partial = m_partial_q;
`endif

  assign m_valid = m_valid_q;

endmodule

// File: doc/spshift_ctrl.md
# spshift_ctrl

Sequencing controller for the generalized serial-to-parallel shift register (`spshiftreg`). It accepts N-bit chunks over a valid/ready stream and drives the register's enable, clear and serial input. After M chunks it presents the assembled M*N-bit word through a valid/ready output handshake. It sits between a chunk producer (UART/SPI deserializer front end) and any word-wide consumer; the word data itself is taken directly from the shift register's `q`.

## Interface
- `N`, 4, bits per chunk (must match the shift register's `N`)
- `M`, 2, chunks per word, ≥ 2 (must match the shift register's `M`)
- `LW`, derived = `$clog2(M+1)`, width of `level`
- `clk`  in  1  system clock; one clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  input chunk valid
- `s_ready`  out  1  controller can accept a chunk this cycle
- `s_data`  in  N  input chunk
- `flush`  in  1  pad and emit a partial word (only with `SPSHIFT_CTRL_FLUSH_EN`)
- `m_valid`  out  1  assembled word on shift register `q` is valid
- `m_ready`  in  1  consumer takes the word
- `m_partial`  out  1  current word was zero-padded (only with `SPSHIFT_CTRL_FLUSH_EN`)
- `sr_en`  out  1  to the shift register's `en`
- `sr_clr`  out  1  to the shift register's (synchronous, active-high) `reset`
- `sr_sin`  out  N  to the shift register's `sin`
- `level`  out  LW  chunks currently held, 0..M

## Operation
- States: INIT, FILL, PAD, FULL. Reset value: INIT, `level`=0, `m_partial`=0.
- **INIT** (exactly one cycle after `reset_n` rises):
  - `sr_clr`=1, `s_ready`=0, `sr_en`=0.
  - Next state: FILL.
- **FILL**:
  - `s_ready`=1, `sr_sin`=`s_data`, `sr_en`=`s_valid`.
  - On accept, `level`+1.
  - When the accept brings `level` to M, go to FULL.
- **FULL**:
  - `m_valid`=1; `s_ready`=`m_ready`.
  - Output handshake (`m_valid`&&`m_ready`) without a simultaneous input accept: `level`←0, go to FILL.
  - Output handshake with a simultaneous input accept: that chunk is shifted in (`sr_en`=1), `level`←1, go to FILL. This gives full throughput of one word per M cycles.
  - Word data is valid on `q` for the entire FULL residency; `q` changes only on the handshake edge.
- `m_valid`=0 outside FULL.
- `sr_clr`=0 outside INIT.
- `sr_sin`=0 whenever `s_ready`=0.
- `level` never exceeds M. Chunks are never dropped or duplicated; the first chunk accepted ends up in the most-significant N bits of `q`.

## Timing
- `s_ready`, `sr_en`, `sr_sin` and `sr_clr` are combinational from the state and `s_valid`/`m_ready`/`flush`. No input-to-`s_ready` path exists except `m_ready` in FULL.
- `m_valid`, `m_partial` and `level` are registered.
- Latency: `m_valid` rises in the cycle after the edge that accepted the M-th chunk.
- `s_valid` is ignored while `s_ready`=0. Producers must hold `s_data` stable until accepted.
- Reset mid-operation (`reset_n` low in any state): immediately INIT, `m_valid`=0, `level`=0. Any partial word is discarded; the shift register is cleared during the INIT cycle.

## Configuration
- Macro: `SPSHIFT_CTRL_FLUSH_EN`.
- **Defined**:
  - `flush` in FILL with `level`>0: that cycle `s_ready`=0, `sr_en`=1, `sr_sin`=0 (first pad), `level`+1.
  - If the new `level` is M, go to FULL; otherwise go to PAD.
  - PAD: `s_ready`=0, `sr_en`=1, `sr_sin`=0 each cycle until `level`=M, then FULL.
  - `m_partial` is set on entry to FULL via a flush and cleared on the output handshake.
  - Real chunks occupy the upper bits of `q`; the lower bits are zero.
  - `flush` with `level`=0, or in INIT/FULL/PAD, is ignored.
- **Undefined**: the `flush` and `m_partial` ports and the PAD state are absent. `m_partial` behaviour does not exist.

## Structure
- Package `spshift_pkg`:
  - `spshift_state_t` enum {INIT, FILL, PAD, FULL}; PAD is kept in the enum even when the feature is off.
  - Helper function for the `LW` width.
- One sub-module, `modcounter`: an up counter with parameterized width and modulus. It has async active-low reset and `inc`/`clr` inputs and holds `level`. It saturates at M; `clr`+`inc` in the same cycle yields 1.
- The controller does not instantiate the shift register. The integration top connects `sr_*` to `spshiftreg`.

## Test plan
Defaults N=4, M=2 unless stated.
- Reset and INIT: after `reset_n` rises, `sr_clr`=1 for one cycle and `s_ready`=0, then `s_ready`=1 with `level`=0 and `m_valid`=0.
- Basic assembly: chunks 0xA then 0xB, `m_ready`=0 → `m_valid`=1 one cycle after the 0xB accept, `q`=0xAB held; `s_ready`=0 until `m_ready`=1.
- Back-to-back throughput: continuous `s_valid` with 0x1,0x2,0x3,0x4 and `m_ready`=1 → words 0x12 then 0x34, one word every 2 cycles, no stalls.
- Reset mid-word: accept 0x5, assert `reset_n`=0 → `level`=0 and `m_valid`=0 immediately. Next word 0x6,0x7 yields 0x67.
- Flush (macro defined, M=4): accept 0x9, pulse `flush` → 3 pad cycles, then `m_valid`=1, `m_partial`=1, `q`=0x9000. `flush` at `level`=0 has no effect.
- Backpressure randomization: random `s_valid`/`m_ready` over 1000 chunks. A scoreboard checks word order and that `level`≤M at all times.
